// File: rtl/frame_window_sampler.sv
// Captures a decimated rectangular window of an active-video pixel stream into
// one RAM per channel plane, and serves the planes through a registered read port.
//
// state    | meaning
// IDLE     | waiting for i_start
// ARM      | waiting for the first pixel (sof) of the next frame
// CAPTURE  | walking the frame and writing decimated window samples
module frame_window_sampler #(
  parameter int DW    = 10,
  parameter int CH    = 3,
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int WIN_X = 128,
  parameter int WIN_Y = 48,
  parameter int WIN_W = 384,
  parameter int WIN_H = 384,
  parameter int DEC   = 3,
  localparam int OW    = WIN_W / DEC,
  localparam int OH    = WIN_H / DEC,
  localparam int PLANE = OW * OH,
  localparam int AW    = (CH * PLANE > 1) ? $clog2(CH * PLANE) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic [CH*DW-1:0] i_pixel,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [DW-1:0]    o_rd_data,
  output logic             o_rd_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_frame_err
);

  localparam int XW  = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW  = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int IW  = (OW > 1) ? $clog2(OW + 1) : 1;
  localparam int JW  = (OH > 1) ? $clog2(OH + 1) : 1;
  localparam int DPW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int PAW = (PLANE > 1) ? $clog2(PLANE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE} state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [DPW-1:0]     px_q, px_d, py_q, py_d;
  logic [IW-1:0]      i_q, i_d;
  logic [JW-1:0]      j_q, j_d;
  logic               last_q, last_d;
  logic               wr_en_q, wr_en_d;
  logic [PAW-1:0]     wr_addr_q, wr_addr_d;
  logic [CH*DW-1:0]   wr_data_q, wr_data_d;
  logic               done_q, done_d;
  logic               frame_err_q, frame_err_d;
  logic [DW-1:0]      rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic               accept_first, walk, short_frame, adv;
  logic               in_x, in_y, line_end, sample, final_sample;
  logic [CH-1:0][DW-1:0] plane_word;
  logic [DW-1:0]      rd_word;

  // After the final sample (last_q) the rest of the frame is ignored.
  always_comb begin
    accept_first = (state_q == S_ARM) && i_valid && i_sof;
    walk         = (state_q == S_CAPTURE) && !last_q && i_valid && !i_sof;
    short_frame  = (state_q == S_CAPTURE) && !last_q && i_valid && i_sof;
    adv          = accept_first || walk;
    in_x         = (int'(x_q) >= WIN_X) && (int'(x_q) < WIN_X + WIN_W);
    in_y         = (int'(y_q) >= WIN_Y) && (int'(y_q) < WIN_Y + WIN_H);
    line_end     = (x_q == XW'(H_ACT - 1));
    sample       = adv && in_x && in_y && (px_q == '0) && (py_q == '0);
    final_sample = sample && (i_q == IW'(OW - 1)) && (j_q == JW'(OH - 1));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_start) state_d = S_ARM;
      S_ARM:     if (accept_first) state_d = S_CAPTURE;
      S_CAPTURE: if (last_q || short_frame) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q != S_IDLE);
  end

  // Position, phase and sample-index counters; the sof pixel in ARM is (0,0).
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    px_d      = px_q;
    py_d      = py_q;
    i_d       = i_q;
    j_d       = j_q;
    last_d    = last_q;
    if ((state_q != S_CAPTURE) && !accept_first) begin
      x_d    = '0;
      y_d    = '0;
      px_d   = '0;
      py_d   = '0;
      i_d    = '0;
      j_d    = '0;
      last_d = 1'b0;
    end else if (adv) begin
      if (final_sample) last_d = 1'b1;
      if (line_end) begin
        x_d  = '0;
        px_d = '0;
        i_d  = '0;
        if (y_q != YW'(V_ACT - 1)) y_d = y_q + 1'b1;
        if (in_y) begin
          py_d = (py_q == DPW'(DEC - 1)) ? '0 : py_q + 1'b1;
          if (py_q == '0) j_d = j_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
        if (in_x) px_d = (px_q == DPW'(DEC - 1)) ? '0 : px_q + 1'b1;
        if (sample) i_d = i_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_en_d     = sample;
    wr_addr_d   = sample ? PAW'(int'(j_q) * OW + int'(i_q)) : wr_addr_q;
    wr_data_d   = sample ? i_pixel : wr_data_q;
    done_d      = (state_q == S_CAPTURE) && last_q;
    frame_err_d = frame_err_q;
    if ((state_q == S_IDLE) && i_start) frame_err_d = 1'b0;
    else if (short_frame)               frame_err_d = 1'b1;
  end

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < CH; c++) begin
      if ((int'(i_rd_addr) >= c * PLANE) && (int'(i_rd_addr) < (c + 1) * PLANE))
        rd_word = plane_word[c];
    end
    rd_valid_d = i_rd_en;
    rd_data_d  = i_rd_en ? rd_word : rd_data_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      last_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      px_q        <= px_d;
      py_q        <= py_d;
      i_q         <= i_d;
      j_q         <= j_d;
      last_q      <= last_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // One single-write-port RAM per channel plane; reads see pre-write data.
  for (genvar c = 0; c < CH; c++) begin : g_plane
    logic [DW-1:0]  mem_q [PLANE];
    logic [PAW-1:0] rd_off;

    always_ff @(posedge i_clk) begin
      if (wr_en_q) mem_q[wr_addr_q] <= wr_data_q[c*DW +: DW];
    end

    assign rd_off        = PAW'(int'(i_rd_addr) - c * PLANE);
    assign plane_word[c] = mem_q[rd_off];
  end

  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_done      = done_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_frame_window_sampler.sv
// Scoreboard bench for frame_window_sampler: frames are driven with random
// valid gaps and data, expected RAM contents come from window/decimation arithmetic.
module tb_frame_window_sampler;

  localparam int DW = 10, CH = 3, H_ACT = 16, V_ACT = 8;
  localparam int WIN_X = 4, WIN_Y = 2, WIN_W = 6, WIN_H = 4, DEC = 2;
  localparam int OW = WIN_W / DEC, OH = WIN_H / DEC, PLANE = OW * OH;
  localparam int AW = $clog2(CH * PLANE);
  localparam int NPIX = H_ACT * V_ACT;

  typedef struct {
    int          addr;
    int          data;
    int          due;
  } rd_exp_t;

  logic             clk, rst_n;
  logic             i_start, i_valid, i_sof, i_rd_en;
  logic [CH*DW-1:0] i_pixel;
  logic [AW-1:0]    i_rd_addr;
  logic [DW-1:0]    o_rd_data;
  logic             o_rd_valid, o_busy, o_done, o_frame_err;

  int               cyc = 0;
  int               n_cmp = 0;
  int               n_err = 0;
  bit               chk_busy = 0;
  bit               busy_dropped = 0;
  rd_exp_t          rd_q[$];
  int               done_q[$];
  logic [CH*DW-1:0] fr [NPIX];
  int               exp_mem [CH*PLANE];

  frame_window_sampler #(
    .DW(DW), .CH(CH), .H_ACT(H_ACT), .V_ACT(V_ACT), .WIN_X(WIN_X), .WIN_Y(WIN_Y),
    .WIN_W(WIN_W), .WIN_H(WIN_H), .DEC(DEC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_valid(i_valid), .i_sof(i_sof),
    .i_pixel(i_pixel), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .o_busy(o_busy), .o_done(o_done), .o_frame_err(o_frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name, input int act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: observed %0d with nothing expected (cycle %0d)", name, act, cyc);
  endfunction

  // Monitor: pops expectations whenever the DUT presents read data or o_done.
  always @(negedge clk) begin
    rd_exp_t e;
    int      d;
    if (rst_n) begin
      if (o_rd_valid) begin
        if (rd_q.size() == 0) fail_now("rd_unexpected", int'(o_rd_data));
        else begin
          e = rd_q.pop_front();
          check($sformatf("rd_data[%0d]", e.addr), int'(o_rd_data), e.data);
          check($sformatf("rd_latency[%0d]", e.addr), cyc, e.due);
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        e = rd_q.pop_front();
        check($sformatf("rd_valid_missing[%0d]", e.addr), int'(o_rd_valid), 1);
      end
      if (o_done) begin
        if (done_q.size() == 0) fail_now("done_unexpected", cyc);
        else begin
          d = done_q.pop_front();
          check("done_cycle", cyc, d);
        end
        chk_busy = 0;
      end
      if (chk_busy && !o_busy && !o_done) busy_dropped = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // gap_mode: 0 continuous, 1 valid low every other cycle, 2 random gaps.
  task automatic drive_frame(input int gap_mode, input bit rnd, input bit expect_cap,
                             input int cut, input int npix, input bit start_first);
    int x, y, ng;
    logic [CH*DW-1:0] pix;
    for (int p = 0; p < npix; p++) begin
      x  = p % H_ACT;
      y  = p / H_ACT;
      ng = (gap_mode == 2) ? int'($urandom_range(0, 2)) : ((gap_mode == 1 && p > 0) ? 1 : 0);
      for (int k = 0; k < ng; k++) begin
        i_valid = 1'b0;
        i_sof   = 1'($urandom_range(0, 1));
        i_pixel = (CH*DW)'($urandom);
        i_start = 1'b0;
        tick();
      end
      for (int c = 0; c < CH; c++)
        pix[c*DW +: DW] = rnd ? DW'($urandom) : DW'(c * 256 + y * 16 + x);
      fr[p]   = pix;
      i_valid = 1'b1;
      i_sof   = (p == 0) || (p == cut);
      i_pixel = pix;
      i_start = start_first && (p == 0);
      if (expect_cap && x == WIN_X + (OW - 1) * DEC && y == WIN_Y + (OH - 1) * DEC)
        done_q.push_back(cyc + 2);
      tick();
      if (start_first && p == 0) chk_busy = 1;
      if (p == cut) break;
    end
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_start = 1'b0;
    if (expect_cap) begin
      for (int c = 0; c < CH; c++)
        for (int j = 0; j < OH; j++)
          for (int i = 0; i < OW; i++)
            exp_mem[c*PLANE + j*OW + i] =
              int'(fr[(WIN_Y + j*DEC) * H_ACT + WIN_X + i*DEC][c*DW +: DW]);
    end
  endtask

  task automatic issue_read(input int addr, input int exp);
    i_rd_en   = 1'b1;
    i_rd_addr = AW'(addr);
    rd_q.push_back('{addr, exp, cyc + 1});
    tick();
    i_rd_en   = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < CH * PLANE; a++) issue_read(a, exp_mem[a]);
  endtask

  task automatic read_random(input int n);
    int a;
    for (int k = 0; k < n; k++) begin
      a = int'($urandom_range(0, (1 << AW) - 1));
      issue_read(a, (a < CH * PLANE) ? exp_mem[a] : 0);
    end
  endtask

  task automatic drain(input string tag);
    tick();
    tick();
    check({tag, "_rd_pending"}, rd_q.size(), 0);
  endtask

  task automatic settle(input string tag);
    repeat (4) tick();
    check({tag, "_done_pending"}, done_q.size(), 0);
    check({tag, "_busy_idle"}, int'(o_busy), 0);
    check({tag, "_done_low"}, int'(o_done), 0);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
    i_pixel = '0; i_rd_en = 1'b0; i_rd_addr = '0;
    tick();
    tick();
    check("rst_rd_data", int'(o_rd_data), 0);
    check("rst_rd_valid", int'(o_rd_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_frame_err", int'(o_frame_err), 0);
    rst_n = 1'b1;
    tick();

    // full frame, continuous valid, formula pixels
    pulse_start();
    check("t1_busy_start", int'(o_busy), 1);
    drive_frame(0, 0, 1, -1, NPIX, 0);
    settle("t1");
    issue_read(0, 36);
    issue_read(5, 72);
    issue_read(6, 292);
    issue_read(17, 584);
    read_all();
    drain("t1");
    check("t1_hold_valid", int'(o_rd_valid), 0);
    check("t1_hold_data", int'(o_rd_data), 584);

    // random data, random gaps
    pulse_start();
    drive_frame(2, 1, 1, -1, NPIX, 0);
    settle("trnd");
    read_all();
    read_random(12);
    drain("trnd");

    // valid low every other cycle, formula pixels
    pulse_start();
    drive_frame(1, 0, 1, -1, NPIX, 0);
    settle("t2");
    issue_read(0, 36);
    issue_read(5, 72);
    read_all();
    drain("t2");

    // i_start together with sof: frame 1 ignored, frame 2 captured
    busy_dropped = 0;
    drive_frame(2, 1, 0, -1, NPIX, 1);
    drive_frame(0, 1, 1, -1, NPIX, 0);
    settle("t3");
    check("t3_busy_held", int'(busy_dropped), 0);
    read_all();
    drain("t3");

    // short frame: sof at pixel 50
    pulse_start();
    drive_frame(0, 1, 0, 50, 51, 0);
    check("t4_err_set", int'(o_frame_err), 1);
    check("t4_busy_low", int'(o_busy), 0);
    repeat (4) tick();
    check("t4_err_sticky", int'(o_frame_err), 1);
    check("t4_no_rearm", int'(o_busy), 0);
    check("t4_no_done", done_q.size(), 0);
    pulse_start();
    check("t4_err_cleared", int'(o_frame_err), 0);
    check("t4_busy_restart", int'(o_busy), 1);
    drive_frame(0, 0, 1, -1, NPIX, 0);
    settle("t4");
    read_all();
    drain("t4");

    // reset mid-capture
    pulse_start();
    drive_frame(0, 1, 0, -1, 60, 0);
    check("t5_busy_before", int'(o_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_rd_data", int'(o_rd_data), 0);
    check("t5_rst_rd_valid", int'(o_rd_valid), 0);
    check("t5_rst_busy", int'(o_busy), 0);
    check("t5_rst_done", int'(o_done), 0);
    check("t5_rst_err", int'(o_frame_err), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_idle_after", int'(o_busy), 0);
    pulse_start();
    drive_frame(2, 1, 1, -1, NPIX, 0);
    settle("t5");
    read_all();
    drain("t5");

    // out-of-range read and back-to-back stream
    issue_read(18, 0);
    issue_read(31, 0);
    read_all();
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_window_sampler.md
Name: frame_window_sampler

Overview:
- Captures a rectangular window from an active-video RGB pixel stream and decimates it by an integer factor.
- Stores the result planar, one plane per channel, in on-chip RAM, and serves it through a registered random-access read port.
- Successor to the fixed 384x384 to 128x128 interpolation capture: window, decimation, channel count and data width are parameters; it adds valid-qualified streaming, frame-error detection and a read port.
- Sits between the camera/SDRAM pixel path and the tracking logic.

Parameters:
- DW, 10, bits per channel sample.
- CH, 3, channel count; pixel channel c occupies bits [c*DW +: DW], so channel 0 is R for RGB.
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- WIN_X, 128, first captured column.
- WIN_Y, 48, first captured line.
- WIN_W, 384, window width; must be a multiple of DEC, with WIN_X+WIN_W <= H_ACT.
- WIN_H, 384, window height; must be a multiple of DEC, with WIN_Y+WIN_H <= V_ACT.
- DEC, 3, decimation factor, >= 1, need not be a power of two.
- Derived values: OW=WIN_W/DEC; OH=WIN_H/DEC; PLANE=OW*OH; AW=clog2(CH*PLANE).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse; arms capture of the next frame.
- i_valid  in  1  pixel qualifier.
- i_sof  in  1  first pixel of frame; meaningful only with i_valid.
- i_pixel  in  CH*DW  pixel channels.
- i_rd_en  in  1  read strobe.
- i_rd_addr  in  AW  read address = c*PLANE + j*OW + i.
- o_rd_data  out  DW  read data.
- o_rd_valid  out  1  read data qualifier.
- o_busy  out  1  high in ARM or CAPTURE.
- o_done  out  1  one-cycle pulse when the capture completes.
- o_frame_err  out  1  sticky short-frame flag.

Behaviour:
- Reset: o_rd_data=0, o_rd_valid=0, o_busy=0, o_done=0, o_frame_err=0; state IDLE; all counters 0. RAM contents are not cleared and are undefined after reset.
- Reset mid-capture aborts the capture immediately; no o_done is produced.
- States: IDLE, ARM, CAPTURE.
- IDLE to ARM on i_start. An i_sof in the same cycle is ignored; capture begins on the following frame.
- ARM to CAPTURE on a cycle with i_valid && i_sof. That pixel is treated as (x=0, y=0).
- CAPTURE to IDLE after the last sample is written (see completion below), or on a short frame (see below).
- i_start is ignored outside IDLE.
- Counters: x in 0..H_ACT-1 and y in 0..V_ACT-1 advance only on i_valid. x wraps to 0 and increments y; y saturates at V_ACT-1. Cycles with i_valid low hold all state.
- Sampling: phase counters px and py run 0..DEC-1 inside the window; no division or modulo hardware is used.
- A pixel is sampled when WIN_X <= x < WIN_X+WIN_W, WIN_Y <= y < WIN_Y+WIN_H, px==0 and py==0.
- Sample index: i=(x-WIN_X)/DEC and j=(y-WIN_Y)/DEC, tracked by counters.
- Write timing: a pixel accepted at edge N is written at edge N+1 into every channel plane simultaneously, at address j*OW+i of plane c. Each plane is a separate RAM with one write port.
- Completion: let edge N accept the sample with i=OW-1, j=OH-1.
  - At edge N+1: the write happens, o_busy falls and o_done rises.
  - At edge N+2: o_done falls.
  - Remaining pixels of the frame are ignored.
- Short frame: i_valid && i_sof in CAPTURE before completion sets o_frame_err=1 and returns to IDLE; no o_done. The new sof does not re-arm.
- o_frame_err clears on the next accepted i_start.
- Read port: i_rd_en at edge N gives o_rd_data and o_rd_valid=1 after edge N+1.
  - o_rd_valid is low the cycle after a non-read; o_rd_data holds its last value.
  - Addresses >= CH*PLANE return 0 with o_rd_valid=1.
- Reads are allowed in any state. A read and a write to the same location on the same edge returns the old data.

Test Plan:
- Common bench setup:
  - Parameters: DW=10, CH=3, H_ACT=16, V_ACT=8, WIN_X=4, WIN_Y=2, WIN_W=6, WIN_H=4, DEC=2, giving OW=3, OH=2, PLANE=6.
  - Stimulus: pixel channel c = c*256 + y*16 + x.
- Full frame with continuous valid:
  - o_done pulses once, 2 edges after pixel 72 (x=8, y=4) is accepted.
  - Reads: addr 0 returns 36, addr 5 returns 72, addr 6 returns 292, addr 17 returns 584.
- Same frame with i_valid low every other cycle:
  - Identical RAM contents.
  - o_done 2 edges after pixel 72 is accepted.
- i_start and i_sof in the same cycle:
  - Frame 1 is ignored, frame 2 is captured.
  - o_busy stays high from i_start until done.
- Short frame, i_sof at pixel index 50 of the captured frame:
  - o_frame_err=1, no o_done, o_busy=0.
  - The next i_start clears o_frame_err.
- Reset asserted mid-capture:
  - All outputs 0 immediately.
  - After release, i_start plus a full frame captures correctly.
- Read addr 18:
  - o_rd_data=0 with o_rd_valid=1 one cycle later.
  - Back-to-back reads of addr 0..17 stream with 1-cycle latency.
